// File: rtl/div_seq_16by8.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_16by8
// Description : Sequential restoring divider. Divides a 2*size-bit unsigned
//               dividend by a size-bit unsigned divisor, one radix-2 step per
//               clock, MSB of the dividend first.
//               It uses an enable-in / enable-out handshake: a request is
//               accepted only while div_ready is high. div_en_out pulses for
//               one cycle when the results are valid.
// Ports       :
//   clk         in   1        clock, rising edge
//   rst_n       in   1        asynchronous active-low reset
//   div_en_in   in   1        request, sampled when div_ready is high
//   div_a       in   2*size   dividend (unsigned)
//   div_b       in   size     divisor (unsigned)
//   div_ready   out  1        high only while idle
//   div_en_out  out  1        one-cycle result-valid pulse
//   div_quot    out  2*size   quotient (held until next result)
//   div_rem     out  size     remainder (held until next result)
//   div_zero    out  1        divisor was zero for the reported result
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq_16by8 #(
  parameter int size = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                div_en_in,
  input  logic [2*size-1:0]   div_a,
  input  logic [size-1:0]     div_b,
  output logic                div_ready,
  output logic                div_en_out,
  output logic [2*size-1:0]   div_quot,
  output logic [size-1:0]     div_rem,
  output logic                div_zero
);

  localparam int c_STEPS = 2 * size;
  localparam int c_CW    = $clog2(c_STEPS);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_STEPS - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [c_CW-1:0]    r_cnt;
  // Dividend and quotient share one shift register: each step moves the
  // next dividend bit out of the MSB and the new quotient bit into the LSB.
  // After 2*size steps it holds only the quotient.
  logic [2*size-1:0]  r_dq;
  logic [size-1:0]    r_divisor;
  logic [size-1:0]    r_p;
  logic               r_zero;
  logic               r_en_out;
  logic [2*size-1:0]  r_quot;
  logic [size-1:0]    r_rem;
  logic               r_zero_out;

  logic [size:0]      w_p_shift;
  logic               w_ge;
  logic [size-1:0]    w_p_next;
  logic [2*size-1:0]  w_dq_next;
  logic               w_last;

  // The working partial remainder is size+1 bits. A stored remainder always
  // fits in size bits. When the subtraction happens, the true difference is
  // below 2^size for a non-zero divisor, so a size-bit subtract is exact.
  // With a zero divisor the compare always succeeds. The register then just
  // collects the last size dividend bits, which is the required remainder.
  assign w_p_shift = {r_p, r_dq[2*size-1]};
  assign w_ge      = (w_p_shift >= {1'b0, r_divisor});
  assign w_p_next  = w_ge ? (w_p_shift[size-1:0] - r_divisor) : w_p_shift[size-1:0];
  assign w_dq_next = {r_dq[2*size-2:0], w_ge};
  assign w_last    = (r_cnt == c_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_cnt      <= '0;
      r_dq       <= '0;
      r_divisor  <= '0;
      r_p        <= '0;
      r_zero     <= 1'b0;
      r_en_out   <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_zero_out <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (div_en_in) begin
            r_dq      <= div_a;
            r_divisor <= div_b;
            r_zero    <= (div_b == '0);
            r_p       <= '0;
            r_cnt     <= '0;
            r_state   <= c_BUSY;
          end
        end
        c_BUSY: begin
          r_p   <= w_p_next;
          r_dq  <= w_dq_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state    <= c_DONE;
            r_cnt      <= '0;
            r_quot     <= w_dq_next;
            r_rem      <= w_p_next;
            r_zero_out <= r_zero;
            r_en_out   <= 1'b1;
          end
        end
        c_DONE: begin
          r_en_out <= 1'b0;
          r_state  <= c_IDLE;
        end
        default: begin
          r_en_out <= 1'b0;
          r_state  <= c_IDLE;
        end
      endcase
    end
  end

  assign div_ready  = (r_state == c_IDLE);
  assign div_en_out = r_en_out;
  assign div_quot   = r_quot;
  assign div_rem    = r_rem;
  assign div_zero   = r_zero_out;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_16by8.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq_16by8
// Description : Scoreboard testbench for div_seq_16by8. The stimulus pushes
//               arithmetic expectations into a queue. A negedge monitor pops
//               an expectation on every div_en_out pulse and checks it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq_16by8;

  logic        clk;
  logic        rst_n;
  logic        div_en_in;
  logic [15:0] div_a;
  logic [7:0]  div_b;
  logic        div_ready;
  logic        div_en_out;
  logic [15:0] div_quot;
  logic [7:0]  div_rem;
  logic        div_zero;

  div_seq_16by8 #(.size(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_en_in  (div_en_in),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_ready  (div_ready),
    .div_en_out (div_en_out),
    .div_quot   (div_quot),
    .div_rem    (div_rem),
    .div_zero   (div_zero)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] quot;
    logic [7:0]  rem;
    logic        zero;
    int          t;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer division. A zero divisor gives an
  // all-ones quotient, and the remainder is the dividend's low byte.
  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input int t);
    exp_t e;
    e.a = a;
    e.b = b;
    e.t = t;
    if (b == 8'd0) begin
      e.quot = 16'hFFFF;
      e.rem  = a[7:0];
      e.zero = 1'b1;
    end else begin
      e.quot = a / {8'd0, b};
      e.rem  = 8'(a % {8'd0, b});
      e.zero = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input logic [15:0] a, input logic [7:0] b);
    int t = 0;
    while (!div_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!div_ready) begin
      checks++;
      fails++;
      $display("FAIL issue_timeout ready=%0d expected=1", div_ready);
      return;
    end
    div_en_in = 1'b1;
    div_a     = a;
    div_b     = b;
    q.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    div_en_in = 1'b0;
    div_a     = 16'($urandom);
    div_b     = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || !div_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0 || !div_ready) begin
      checks++;
      fails++;
      $display("FAIL idle_timeout pending=%0d expected=0", q.size());
      q.delete();
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && div_en_out) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_result quot=%0d rem=%0d expected=no result", div_quot, div_rem);
      end else begin
        m_e = q.pop_front();
        chk("quot",    32'(div_quot),   32'(m_e.quot));
        chk("rem",     32'(div_rem),    32'(m_e.rem));
        chk("zero",    32'(div_zero),   32'(m_e.zero));
        chk("latency", 32'(cyc - m_e.t), 32'd16);
        chk("ready_in_done", 32'(div_ready), 32'd0);
        if (!div_zero) begin
          chk("inv_eq", 32'(div_quot) * 32'(m_e.b) + 32'(div_rem), 32'(m_e.a));
          chk("inv_lt", 32'(div_rem < m_e.b), 32'd1);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    rst_n     = 1'b0;
    div_en_in = 1'b0;
    div_a     = '0;
    div_b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(div_ready),  32'd1);
    chk("rst_en",    32'(div_en_out), 32'd0);
    chk("rst_quot",  32'(div_quot),   32'd0);
    chk("rst_rem",   32'(div_rem),    32'd0);
    chk("rst_zero",  32'(div_zero),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed values, including boundary cases.
    issue(16'd1000,  8'd7);
    wait_idle();
    issue(16'd65535, 8'd255);
    wait_idle();
    issue(16'd65535, 8'd1);
    wait_idle();
    issue(16'd100,   8'd200);
    wait_idle();
    issue(16'd5,     8'd0);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("hold_quot", 32'(div_quot), 32'hFFFF);
    chk("hold_rem",  32'(div_rem),  32'd5);
    chk("hold_zero", 32'(div_zero), 32'd1);

    // A request made while busy must be ignored.
    issue(16'd1000, 8'd7);
    repeat (3) @(negedge clk);
    div_en_in = 1'b1;
    div_a     = 16'd9;
    div_b     = 8'd3;
    for (int i = 0; i < 8; i++) begin
      chk("busy_ready", 32'(div_ready), 32'd0);
      @(negedge clk);
    end
    div_en_in = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    // A reset mid-operation discards the in-flight division.
    issue(16'd1000, 8'd7);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(div_ready),  32'd1);
    chk("midrst_en",    32'(div_en_out), 32'd0);
    chk("midrst_quot",  32'(div_quot),   32'd0);
    chk("midrst_rem",   32'(div_rem),    32'd0);
    chk("midrst_zero",  32'(div_zero),   32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(16'd300, 8'd16);
    wait_idle();

    // Random operands, back-to-back, with extra weight on 0 and max values.
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 3))
        0: ra = 16'd0;
        1: ra = 16'hFFFF;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: rb = 8'd0;
        1: rb = 8'hFF;
        2: rb = 8'd1;
        default: rb = 8'($urandom);
      endcase
      issue(ra, rb);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
